imem_pipe: RTL and testbench

Parametrised, pipelined instruction memory with valid/ready request and response handshakes, backpressure stall, fetch flush, a runtime program-load write port and address fault reporting. It sits between the fetch stage and instruction storage. The fetch stage can issue one fetch per cycle, discard wrong-path fetches on a redirect, and receive fault flags instead of silently aliased words. The load port lets a boot loader (e.g. UART) rewrite the program without resynthesis.

---
 rtl/imem_pipe.sv | 93 +++++++++
 tb/tb_imem_pipe.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/imem_pipe.sv
// Pipelined instruction memory: valid/ready fetch port, stall, flush, fault flags,
// and an independent program-load write port (read-first on collision).
module imem_pipe #(
  parameter int                   NUM_WORDS   = 1024,
  parameter int                   WORD_SIZE   = 32,
  parameter int                   ADDR_WIDTH  = 12,
  parameter int                   PIPE_STAGES = 1,
  parameter string                INIT_FILE   = "program.mem",
  parameter logic [WORD_SIZE-1:0] FAULT_INSTR = 32'h00000013
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_WIDTH-1:0]        req_addr,
  input  logic                         flush,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [WORD_SIZE-1:0]         rsp_instr,
  output logic                         rsp_misalign,
  output logic                         rsp_range,
  input  logic                         load_en,
  input  logic [$clog2(NUM_WORDS)-1:0] load_addr,
  input  logic [WORD_SIZE-1:0]         load_data
);
  localparam int OFS = $clog2(WORD_SIZE/8);
  localparam int IW  = ADDR_WIDTH - OFS;
  localparam int LAW = $clog2(NUM_WORDS);
  localparam int S   = PIPE_STAGES;

  logic [WORD_SIZE-1:0]        mem [NUM_WORDS];
  logic [S-1:0]                vld_pipe, vld_nxt, mis_pipe, rng_pipe;
  logic [S-1:0][WORD_SIZE-1:0] dat_pipe;
  logic [IW-1:0]               idx;
  logic                        adv, misalign, range_err;

  assign idx       = req_addr[ADDR_WIDTH-1:OFS];
  assign range_err = 32'(idx) >= NUM_WORDS;

  generate
    if (OFS > 0) begin : g_mis
      assign misalign = |req_addr[OFS-1:0];
    end else begin : g_nomis
      assign misalign = 1'b0;
    end
  endgenerate

  assign adv       = !rsp_valid || rsp_ready;
  assign req_ready = adv;

  // Load port is never gated by stall, flush or reset.
  always_ff @(posedge clk)
    if (load_en && 32'(load_addr) < NUM_WORDS) mem[load_addr] <= load_data;

  // Valid bits: shift on advance; flush kills everything except a request taken this cycle.
  always_comb begin
    vld_nxt    = vld_pipe;
    vld_nxt[0] = adv ? req_valid : vld_pipe[0];
    for (int k = 1; k < S; k++) vld_nxt[k] = adv ? vld_pipe[k-1] : vld_pipe[k];
    if (flush) begin
      vld_nxt    = '0;
      vld_nxt[0] = adv && req_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= vld_nxt;
  end

  // Data and fault flags only move on advance, so outputs stay frozen under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      dat_pipe <= '0;
      mis_pipe <= '0;
      rng_pipe <= '0;
    end else if (adv) begin
      dat_pipe[0] <= mem[idx[LAW-1:0]];
      mis_pipe[0] <= misalign;
      rng_pipe[0] <= range_err;
      for (int k = 1; k < S; k++) begin
        dat_pipe[k] <= dat_pipe[k-1];
        mis_pipe[k] <= mis_pipe[k-1];
        rng_pipe[k] <= rng_pipe[k-1];
      end
    end
  end

  assign rsp_valid    = vld_pipe[S-1];
  assign rsp_misalign = mis_pipe[S-1];
  assign rsp_range    = rng_pipe[S-1];
  assign rsp_instr    = (mis_pipe[S-1] || rng_pipe[S-1]) ? FAULT_INSTR : dat_pipe[S-1];
endmodule

// File: tb/tb_imem_pipe.sv
// Randomized scoreboard bench for imem_pipe: reference model predicts each response
// and the cycle it becomes visible; a negedge monitor compares.
module tb_imem_pipe;
  localparam int NW = 512;
  localparam int S  = 2;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 0, rst = 1;
  logic        req_valid = 0, req_ready, flush = 0;
  logic [11:0] req_addr = '0;
  logic        rsp_valid, rsp_ready = 0, rsp_misalign, rsp_range;
  logic [31:0] rsp_instr;
  logic        load_en = 0;
  logic [8:0]  load_addr = '0;
  logic [31:0] load_data = '0;

  int checks = 0, errors = 0;

  imem_pipe #(.NUM_WORDS(NW), .WORD_SIZE(32), .ADDR_WIDTH(12), .PIPE_STAGES(S),
              .INIT_FILE(""), .FAULT_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .flush(flush), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr), .rsp_misalign(rsp_misalign), .rsp_range(rsp_range),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: expected responses in order, each with edges left until visible.
  typedef struct {
    logic [31:0] instr;
    bit          mis;
    bit          rng;
    int          rem;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem_m [NW];
  bit          started = 0, prev_rst = 0;

  always @(negedge clk) begin
    bit   ev, adv;
    exp_t e;
    int   wi;
    ev  = (q.size() > 0) && (q[0].rem == 0);
    adv = !ev || rsp_ready;
    if (started) begin
      chk("rsp_valid", rsp_valid, ev);
      chk("req_ready", req_ready, adv);
      if (prev_rst) begin
        chk("rst_instr", rsp_instr, 0);
        chk("rst_misalign", rsp_misalign, 0);
        chk("rst_range", rsp_range, 0);
      end
      if (ev && rsp_valid) begin
        chk("rsp_instr", rsp_instr, q[0].instr);
        chk("rsp_misalign", rsp_misalign, q[0].mis);
        chk("rsp_range", rsp_range, q[0].rng);
      end
    end
    if (rst) q.delete();
    else begin
      if (ev && rsp_ready) void'(q.pop_front());
      if (adv) foreach (q[i]) if (q[i].rem > 0) q[i].rem--;
      if (flush) q.delete();
      if (adv && req_valid) begin
        wi      = int'(req_addr) / 4;
        e.mis   = (req_addr % 4) != 0;
        e.rng   = wi >= NW;
        e.instr = (e.mis || e.rng) ? NOP : mem_m[wi];
        e.rem   = S - 1;
        q.push_back(e);
      end
    end
    // Loads land after the read, giving read-first behaviour.
    if (load_en && int'(load_addr) < NW) mem_m[load_addr] = load_data;
    prev_rst = rst;
    if (rst) started = 1;
  end

  task automatic step(bit v, logic [11:0] a, bit rr, bit fl = 0, bit le = 0,
                      logic [8:0] la = '0, logic [31:0] ld = '0, bit r = 0);
    req_valid = v; req_addr = a; rsp_ready = rr; flush = fl;
    load_en = le; load_addr = la; load_data = ld; rst = r;
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, '0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int          p;
    logic [11:0] a;
    @(posedge clk); #1;
    step(0, '0, 0, 0, 0, '0, '0, 1);
    step(0, '0, 0, 0, 0, '0, '0, 1);

    // Storage is not reset: give every word a known value first.
    for (int i = 0; i < NW; i++) step(0, '0, 1, 0, 1, 9'(i), $urandom);
    idle(2);

    // Back-to-back fetches, no stall.
    step(1, 12'h000, 1); step(1, 12'h004, 1); step(1, 12'h008, 1);
    idle(4);

    // Backpressure mid-stream.
    step(1, 12'h010, 1); step(1, 12'h014, 1); step(1, 12'h018, 1);
    step(1, 12'h01C, 0); step(1, 12'h01C, 0); step(1, 12'h01C, 0);
    step(1, 12'h01C, 1); step(1, 12'h020, 1);
    idle(4);

    // Faults: misaligned, out of range, both, last legal word.
    step(1, 12'h002, 1); step(1, 12'h800, 1); step(1, 12'h803, 1); step(1, 12'h7FC, 1);
    idle(4);

    // Flush with two in flight plus a new fetch of 0x040.
    step(1, 12'h000, 1); step(1, 12'h004, 1); step(1, 12'h040, 1, 1);
    idle(4);

    // Flush while stalled.
    step(1, 12'h020, 1); step(1, 12'h024, 1); step(0, '0, 0); step(0, '0, 0, 1);
    idle(3);

    // Load/fetch collision on word 5, then refetch.
    step(1, 12'h014, 1, 0, 1, 9'd5, 32'hDEADBEEF);
    step(1, 12'h014, 1);
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      p = $urandom_range(0, 99);
      if (p < 70) a = {1'b0, 9'($urandom_range(0, NW-1)), 2'b00};
      else        a = 12'($urandom);
      step($urandom_range(0, 3) != 0, a, $urandom_range(0, 3) != 0,
           $urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0,
           9'($urandom), $urandom, $urandom_range(0, 299) == 0);
    end
    idle(4);

    // Reset during a stalled stream, together with flush, request and load.
    step(1, 12'h030, 0); step(1, 12'h034, 0); step(1, 12'h038, 0);
    step(1, 12'h010, 0, 1, 1, 9'd7, 32'hCAFEF00D, 1);
    step(1, 12'h01C, 1);
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
